// File: rtl/baggage_drop_pkg.sv
// Shared types for the baggage drop controller: channel states, seven-segment glyphs and the
// state-to-display mapping. The hysteresis option (BAGGAGE_DROP_HYST_EN) does not change this file.
package baggage_drop_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_WAIT = 3'd1,
      ST_QUAL = 3'd2,
      ST_DROP = 3'd3,
      ST_LOCK = 3'd4
   } state_t;

   // Segment order is {g,f,e,d,c,b,a}.
   localparam logic [6:0] SEG_C     = 7'b0111001;
   localparam logic [6:0] SEG_O     = 7'b1011100;
   localparam logic [6:0] SEG_L     = 7'b0111000;
   localparam logic [6:0] SEG_D     = 7'b1011110;
   localparam logic [6:0] SEG_H     = 7'b1110110;
   localparam logic [6:0] SEG_T     = 7'b1111000;
   localparam logic [6:0] SEG_R     = 7'b1010000;
   localparam logic [6:0] SEG_P     = 7'b1110011;
   localparam logic [6:0] SEG_N     = 7'b1010100;
   localparam logic [6:0] SEG_E     = 7'b1111001;
   localparam logic [6:0] SEG_BLANK = 7'b0000000;

   function automatic logic [27:0] state_word(input state_t s);
      logic [27:0] word;
      case (s)
         ST_IDLE:          word = {SEG_C, SEG_O, SEG_L, SEG_D};
         ST_WAIT, ST_QUAL: word = {SEG_BLANK, SEG_H, SEG_O, SEG_T};
         ST_DROP:          word = {SEG_D, SEG_R, SEG_O, SEG_P};
         ST_LOCK:          word = {SEG_D, SEG_O, SEG_N, SEG_E};
         default:          word = {4{SEG_BLANK}};
      endcase
      return word;
   endfunction

endpackage

// File: rtl/baggage_drop_ch.sv
// One hatch: temperature compare, IDLE/WAIT/QUAL/DROP/LOCK sequencer and its counters.
// BAGGAGE_DROP_HYST_EN widens the band that must be crossed to abandon qualification.
module baggage_drop_ch
   import baggage_drop_pkg::*;
#(
   parameter int W        = 16,
   parameter int HOLD_CYC = 4,
   parameter int DROP_CYC = 16,
   parameter int HYST_LSB = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         drop_en,
   input  logic [W-1:0] t_act,
   input  logic [W-1:0] t_lim,
   output state_t       state,
   output logic         drop_activated,
   output logic         drop_done
);

   localparam int QW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
   localparam int DW = (DROP_CYC > 1) ? $clog2(DROP_CYC) : 1;
   localparam logic [QW-1:0] QUAL_LAST = QW'(HOLD_CYC - 1);
   localparam logic [DW-1:0] DROP_LAST = DW'(DROP_CYC - 1);

`ifdef BAGGAGE_DROP_HYST_EN
   localparam bit HYST_EN = 1'b1;
`else
   localparam bit HYST_EN = 1'b0;
`endif

   // With the band disabled the leave threshold collapses to t_lim, i.e. exactly "not below".
   localparam logic [W:0] HYST_ADD = HYST_EN ? (W+1)'(HYST_LSB) : '0;

   state_t         state_nxt;
   logic [QW-1:0]  qual_cnt, qual_cnt_nxt;
   logic [DW-1:0]  drop_cnt, drop_cnt_nxt;
   logic           done_nxt;
   logic           below;
   logic           leave;
   logic [W:0]     leave_thr;

   assign below     = (t_act < t_lim);
   assign leave_thr = {1'b0, t_lim} + HYST_ADD;
   assign leave     = ({1'b0, t_act} >= leave_thr);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         qual_cnt  <= '0;
         drop_cnt  <= '0;
         drop_done <= 1'b0;
      end else begin
         state     <= state_nxt;
         qual_cnt  <= qual_cnt_nxt;
         drop_cnt  <= drop_cnt_nxt;
         drop_done <= done_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      qual_cnt_nxt = qual_cnt;
      drop_cnt_nxt = drop_cnt;
      done_nxt     = 1'b0;
      if (!drop_en) begin
         state_nxt    = ST_IDLE;
         qual_cnt_nxt = '0;
         drop_cnt_nxt = '0;
      end else begin
         case (state)
            ST_IDLE: begin
               state_nxt    = ST_WAIT;
               qual_cnt_nxt = '0;
               drop_cnt_nxt = '0;
            end
            ST_WAIT, ST_QUAL: begin
               if (below) begin
                  if (qual_cnt == QUAL_LAST) begin
                     state_nxt    = ST_DROP;
                     qual_cnt_nxt = '0;
                     drop_cnt_nxt = '0;
                  end else begin
                     state_nxt    = ST_QUAL;
                     qual_cnt_nxt = qual_cnt + 1'b1;
                  end
               end else if (state == ST_QUAL && leave) begin
                  state_nxt    = ST_WAIT;
                  qual_cnt_nxt = '0;
               end
            end
            ST_DROP: begin
               if (drop_cnt == DROP_LAST) begin
                  state_nxt    = ST_LOCK;
                  drop_cnt_nxt = '0;
                  done_nxt     = 1'b1;
               end else begin
                  drop_cnt_nxt = drop_cnt + 1'b1;
               end
            end
            ST_LOCK: state_nxt = ST_LOCK;
            default: begin
               state_nxt    = ST_IDLE;
               qual_cnt_nxt = '0;
               drop_cnt_nxt = '0;
            end
         endcase
      end
   end

   // Pure decode of the state register, so reset removes the drive without waiting for a clock.
   assign drop_activated = (state == ST_DROP);

endmodule

// File: rtl/baggage_drop_ctrl.sv
// Multi-hatch baggage drop controller: per-channel sequencers plus a seven-segment status mux.
// Optional BAGGAGE_DROP_HYST_EN enables the qualification hysteresis band inside each channel.
module baggage_drop_ctrl
   import baggage_drop_pkg::*;
#(
   parameter int INT_W    = 8,
   parameter int FRAC_W   = 8,
   parameter int N_CH     = 2,
   parameter int HOLD_CYC = 4,
   parameter int DROP_CYC = 16,
   parameter int HYST_LSB = 4,
   localparam int W       = INT_W + FRAC_W,
   localparam int SW      = $clog2(N_CH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              drop_en,
   input  logic [N_CH*W-1:0] t_act,
   input  logic [N_CH*W-1:0] t_lim,
   input  logic [SW-1:0]     ch_sel,
   output logic [N_CH-1:0]   drop_activated,
   output logic [N_CH-1:0]   drop_done,
   output logic [6:0]        seven_seg1,
   output logic [6:0]        seven_seg2,
   output logic [6:0]        seven_seg3,
   output logic [6:0]        seven_seg4
);

   state_t      ch_state [N_CH];
   logic [27:0] disp_word;

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      baggage_drop_ch #(
         .W        (W),
         .HOLD_CYC (HOLD_CYC),
         .DROP_CYC (DROP_CYC),
         .HYST_LSB (HYST_LSB)
      ) u_ch (
         .clk            (clk),
         .rst_n          (rst_n),
         .drop_en        (drop_en),
         .t_act          (t_act[i*W +: W]),
         .t_lim          (t_lim[i*W +: W]),
         .state          (ch_state[i]),
         .drop_activated (drop_activated[i]),
         .drop_done      (drop_done[i])
      );
   end

   always_comb begin
      disp_word = {4{SEG_BLANK}};
      if (int'(ch_sel) < N_CH) begin
         disp_word = state_word(ch_state[ch_sel]);
      end
   end

   assign {seven_seg1, seven_seg2, seven_seg3, seven_seg4} = disp_word;

endmodule
